inverse_rotate_top: RTL

- Decoder counterpart of the rotate_top matrix encoder.
- Reads a 5x5x64 state, stored as 64 slices of 25 bits, one slice per read cycle.
- Applies the inverse of the fixed per-lane rotation along z (Keccak rho inverse).
- Emits the 64 decoded slices in order, each as a single write pulse, to a downstream memory or file writer.

---
 rtl/rotate_pkg.sv | 26 ++
 rtl/inv_rot_slice.sv | 18 +
 rtl/inverse_rotate_top.sv | 108 ++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared constants for the Keccak rho encoder/decoder pair: geometry,
// per-lane z offsets and the decoder FSM encoding.
package rotate_pkg;

  localparam int SLICES = 64;
  localparam int LANES  = 25;
  localparam int CW     = 6;

  // Lane i = x + 5*y; the encoder moves lane i from slice z to z + ROT_OFF[i].
  localparam logic [CW-1:0] ROT_OFF [0:LANES-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WR_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/inv_rot_slice.sv
// Combinational rho-inverse for one output slice: bit i of slice z comes
// from buffered slice (z + ROT_OFF[i]) mod 64, lane i.
module inv_rot_slice
  import rotate_pkg::*;
(
  input  logic [CW-1:0]    z,
  input  logic [LANES-1:0] slice_buf [SLICES],
  output logic [LANES-1:0] slice_out
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [CW-1:0] src_idx;
    // 6-bit add wraps mod 64 by construction.
    assign src_idx      = z + ROT_OFF[i];
    assign slice_out[i] = slice_buf[src_idx][i];
  end

endmodule

// File: rtl/inverse_rotate_top.sv
// Buffers 64 input slices, then streams the rho-inverse of each slice out
// as a one-cycle write strobe followed by at least one idle cycle.
module inverse_rotate_top
  import rotate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rotate_en,
  input  logic [LANES-1:0] line_in,
  output logic [CW-1:0]    cnt_value,
  output logic             write_enable,
  output logic [LANES-1:0] write_value,
  output logic [CW-1:0]    write_addr,
  output logic             donee,
  output logic [2:0]       dbg_state
);

  // Handshake: rotate_en is a level sampled only in IDLE; the write side has
  // no backpressure, write_value/write_addr are valid while write_enable=1,
  // and donee stays high until rotate_en is seen low.

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    z_q, z_d;
  logic             we_d, done_d;
  logic [LANES-1:0] wv_d, dec_slice;
  logic [CW-1:0]    wa_d;
  logic [LANES-1:0] slice_buf [SLICES];

  assign dbg_state = state_q;

  inv_rot_slice u_inv_rot_slice (
    .z         (z_q),
    .slice_buf (slice_buf),
    .slice_out (dec_slice)
  );

  // Buffer is deliberately not reset; it is fully rewritten in LOAD.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) slice_buf[cnt_value] <= line_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_value;
    z_d     = z_q;
    we_d    = 1'b0;
    wv_d    = write_value;
    wa_d    = write_addr;
    done_d  = donee;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        done_d = 1'b0;
        if (rotate_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d = cnt_value + 1'b1;
        if (cnt_value == CW'(SLICES - 1)) state_d = ST_WR_HI;
      end
      ST_WR_HI: begin
        we_d    = 1'b1;
        wv_d    = dec_slice;
        wa_d    = z_q;
        state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        if (z_q == CW'(SLICES - 1)) begin
          z_d     = '0;
          state_d = ST_DONE;
        end else begin
          z_d     = z_q + 1'b1;
          state_d = ST_WR_HI;
        end
      end
      ST_DONE: begin
        // donee is guaranteed at least one cycle high before release.
        done_d = 1'b1;
        if (donee && !rotate_en) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_value    <= '0;
      z_q          <= '0;
      write_enable <= 1'b0;
      write_value  <= '0;
      write_addr   <= '0;
      donee        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_value    <= cnt_d;
      z_q          <= z_d;
      write_enable <= we_d;
      write_value  <= wv_d;
      write_addr   <= wa_d;
      donee        <= done_d;
    end
  end

endmodule
